// File: rtl/snake_input_ctrl_if.sv
// Signal bundle between the snake input controller and its surroundings.
//   btn_up/down/left/right/pause : raw asynchronous buttons, active-high
//   game_over                    : death/restart pulse from the game logic
//   accion                       : direction code 0=none 1=up 2=down 3=left 4=right
//   mover                        : one-cycle step strobe
//   running                      : controller is in RUN
// The master modport is the side that drives the buttons and game_over.
// The slave modport is the controller itself.
interface snake_input_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_pause;
    logic       game_over;
    logic [2:0] accion;
    logic       mover;
    logic       running;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_pause, game_over,
        input  accion, mover, running
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_pause, game_over,
        output accion, mover, running
    );
endinterface

// File: rtl/snake_input_ctrl.sv
// Snake input controller: the upstream stage of the snake game logic.
// Each button goes through a synchronizer, a debouncer and a press detector.
// The first legal direction starts the game. Later presses are held in a
// pending slot, and that slot is committed once per step. A pause button
// freezes stepping, and game_over returns the controller to IDLE.
//   uclk  : system clock
//   rst   : synchronous, active-high reset
//   bus   : snake_input_ctrl_if.slave (buttons and game_over in;
//           accion, mover and running out)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for the first legal direction; accion=0, counter=0
//   RUN    | step counter runs, one accion commit and mover per step
//   PAUSED | counter, accion and pending frozen; direction presses dropped
module snake_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP_CYCLES     = 5000000,
    parameter int DB_W            = 20,
    parameter int STEP_W          = 23
) (
    input logic               uclk,
    input logic               rst,
    snake_input_ctrl_if.slave bus
);

    localparam int NBTN    = 5;
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_PAUSE = 4;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] lvl;
    logic [NBTN-1:0] lvl_d;
    logic [NBTN-1:0] press;
    logic [DB_W-1:0] db_cnt [NBTN];

    assign raw = {bus.btn_pause, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    always_ff @(posedge uclk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_d <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_d <= lvl;
            for (int i = 0; i < NBTN; i++) begin
                // The count holds the number of consecutive disagreeing cycles
                // already seen. When the count reaches DB_LAST, the current
                // cycle is the DEBOUNCE_CYCLES-th one.
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    lvl[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // lvl and lvl_d are both registers, so this decode is glitch-free.
    assign press = lvl & ~lvl_d;

    // ------------------------------------------------------------------
    // Direction arbitration: up > down > left > right
    // ------------------------------------------------------------------
    logic [2:0] dir_evt;

    always_comb begin
        dir_evt = DIR_NONE;
        if (press[B_UP]) begin
            dir_evt = DIR_UP;
        end else if (press[B_DOWN]) begin
            dir_evt = DIR_DOWN;
        end else if (press[B_LEFT]) begin
            dir_evt = DIR_LEFT;
        end else if (press[B_RIGHT]) begin
            dir_evt = DIR_RIGHT;
        end
    end

    function automatic logic is_legal(input logic [2:0] dir, input logic [2:0] cur);
        logic opposite;
        opposite = ((dir == DIR_UP)    && (cur == DIR_DOWN))  ||
                   ((dir == DIR_DOWN)  && (cur == DIR_UP))    ||
                   ((dir == DIR_LEFT)  && (cur == DIR_RIGHT)) ||
                   ((dir == DIR_RIGHT) && (cur == DIR_LEFT));
        return (dir != DIR_NONE) && (dir <= DIR_RIGHT) && !opposite;
    endfunction

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_t            state;
    logic [2:0]        accion_q;
    logic [2:0]        pending;
    logic [STEP_W-1:0] step_cnt;
    logic              step_due;
    logic              mover_q;
    logic              running_q;

    assign bus.accion  = accion_q;
    assign bus.mover   = mover_q;
    assign bus.running = running_q;

    always_ff @(posedge uclk) begin
        if (rst || bus.game_over) begin
            state     <= IDLE;
            accion_q  <= DIR_NONE;
            pending   <= DIR_NONE;
            step_cnt  <= '0;
            step_due  <= 1'b0;
            mover_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            // The strobe trails the accion commit by one cycle. This way the
            // downstream stage always sees a settled direction at mover.
            mover_q  <= step_due;
            step_due <= 1'b0;

            case (state)
                IDLE: begin
                    accion_q <= DIR_NONE;
                    step_cnt <= '0;
                    mover_q  <= 1'b0;
                    if (is_legal(dir_evt, DIR_NONE)) begin
                        accion_q  <= dir_evt;
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end

                RUN: begin
                    if (step_cnt >= STEP_LAST) begin
                        step_cnt <= '0;
                        step_due <= 1'b1;
                        pending  <= DIR_NONE;
                        if (is_legal(pending, accion_q)) begin
                            accion_q <= pending;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                    // The event is written after the commit. A press that lands
                    // on the terminal count therefore waits for the next step.
                    if (dir_evt != DIR_NONE) begin
                        pending <= dir_evt;
                    end
                    if (press[B_PAUSE]) begin
                        state     <= PAUSED;
                        running_q <= 1'b0;
                    end
                end

                PAUSED: begin
                    mover_q <= 1'b0;
                    if (press[B_PAUSE]) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    accion_q  <= DIR_NONE;
                    pending   <= DIR_NONE;
                    step_cnt  <= '0;
                    mover_q   <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl. It uses DEBOUNCE_CYCLES=4 and
// STEP_CYCLES=8.
// Edge numbering: e counts uclk edges from the first right-button press.
// All stimulus changes and samples happen 1 time unit after an edge.
module tb_snake_input_ctrl;

    logic uclk;
    logic rst;
    int   checks;
    int   failures;
    int   e;
    int   bad;

    snake_input_ctrl_if bus_if ();

    snake_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .STEP_CYCLES     (8),
        .DB_W            (4),
        .STEP_W          (4)
    ) dut (
        .uclk (uclk),
        .rst  (rst),
        .bus  (bus_if.slave)
    );

    initial uclk = 1'b0;
    always #5 uclk = ~uclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge uclk);
        #1;
        e++;
    endtask

    task automatic run_to(input int target);
        while (e < target) tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        e        = 0;
        rst      = 1'b1;
        bus_if.btn_up    = 1'b0;
        bus_if.btn_down  = 1'b0;
        bus_if.btn_left  = 1'b0;
        bus_if.btn_right = 1'b0;
        bus_if.btn_pause = 1'b0;
        bus_if.game_over = 1'b0;

        // 1: reset and quiet idle
        repeat (3) tick();
        chk("rst_accion", 32'(bus_if.accion), 0);
        chk("rst_mover", 32'(bus_if.mover), 0);
        chk("rst_running", 32'(bus_if.running), 0);
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            tick();
            if (bus_if.accion !== 3'd0 || bus_if.mover !== 1'b0 || bus_if.running !== 1'b0)
                bad++;
        end
        chk("idle_quiet_bad_cycles", 32'(bad), 0);

        // 2: right press starts the game; steps at 8-cycle period
        e = 0;
        bus_if.btn_right = 1'b1;
        run_to(6);
        chk("start_accion_e6", 32'(bus_if.accion), 0);
        chk("start_running_e6", 32'(bus_if.running), 0);
        run_to(7);
        chk("start_accion_e7", 32'(bus_if.accion), 4);
        chk("start_running_e7", 32'(bus_if.running), 1);
        chk("start_mover_e7", 32'(bus_if.mover), 0);
        for (int k = 8; k <= 24; k++) begin
            run_to(k);
            if (k == 10) bus_if.btn_right = 1'b0;
            chk($sformatf("mover_e%0d", k), 32'(bus_if.mover), (k == 16 || k == 24) ? 1 : 0);
        end

        // 3: reversal rejected, then up accepted at the next step
        run_to(26); bus_if.btn_left = 1'b1;
        run_to(34); bus_if.btn_left = 1'b0;
        run_to(39); chk("rev_accion_e39", 32'(bus_if.accion), 4);
        run_to(40); chk("rev_accion_e40", 32'(bus_if.accion), 4);
        chk("rev_mover_e40", 32'(bus_if.mover), 1);
        run_to(42); bus_if.btn_up = 1'b1;
        run_to(50); bus_if.btn_up = 1'b0;
        run_to(54); chk("up_accion_e54", 32'(bus_if.accion), 4);
        run_to(55); chk("up_accion_e55", 32'(bus_if.accion), 1);
        chk("up_mover_e55", 32'(bus_if.mover), 0);
        run_to(56); chk("up_mover_e56", 32'(bus_if.mover), 1);

        // 4: 3-cycle glitch on right is filtered
        run_to(58); bus_if.btn_right = 1'b1;
        run_to(61); bus_if.btn_right = 1'b0;
        run_to(72); chk("glitch_accion_e72", 32'(bus_if.accion), 1);
        run_to(80); chk("glitch_accion_e80", 32'(bus_if.accion), 1);

        // right (legal from up) to get back to accion=4
        run_to(82); bus_if.btn_right = 1'b1;
        run_to(90); bus_if.btn_right = 1'b0;
        run_to(95); chk("right_accion_e95", 32'(bus_if.accion), 4);
        run_to(96); chk("right_mover_e96", 32'(bus_if.mover), 1);

        // 5: up and left together, up wins
        run_to(98); bus_if.btn_up = 1'b1; bus_if.btn_left = 1'b1;
        run_to(106); bus_if.btn_up = 1'b0; bus_if.btn_left = 1'b0;
        run_to(110); chk("prio_accion_e110", 32'(bus_if.accion), 4);
        run_to(111); chk("prio_accion_e111", 32'(bus_if.accion), 1);

        // press event lands on the terminal count: applied one step later
        run_to(120); bus_if.btn_left = 1'b1;
        run_to(127); chk("tc_accion_e127", 32'(bus_if.accion), 1);
        run_to(128); bus_if.btn_left = 1'b0;
        run_to(134); chk("tc_accion_e134", 32'(bus_if.accion), 1);
        run_to(135); chk("tc_accion_e135", 32'(bus_if.accion), 3);
        run_to(136); chk("tc_mover_e136", 32'(bus_if.mover), 1);

        // 6: pause at counter=5, hold 50 cycles, resume; down dropped while paused
        run_to(142); bus_if.btn_pause = 1'b1;
        run_to(148); chk("pause_running_e148", 32'(bus_if.running), 1);
        run_to(149); chk("pause_running_e149", 32'(bus_if.running), 0);
        bad = 0;
        for (int k = 150; k <= 199; k++) begin
            run_to(k);
            if (k == 150) bus_if.btn_pause = 1'b0;
            if (k == 160) bus_if.btn_down = 1'b1;
            if (k == 168) bus_if.btn_down = 1'b0;
            if (bus_if.mover !== 1'b0) bad++;
        end
        chk("paused_mover_count", 32'(bad), 0);
        run_to(200); bus_if.btn_pause = 1'b1;
        run_to(206); chk("resume_running_e206", 32'(bus_if.running), 0);
        run_to(207); chk("resume_running_e207", 32'(bus_if.running), 1);
        run_to(208); bus_if.btn_pause = 1'b0;
        run_to(209); chk("resume_mover_e209", 32'(bus_if.mover), 0);
        run_to(210); chk("resume_mover_e210", 32'(bus_if.mover), 1);
        chk("resume_accion_e210", 32'(bus_if.accion), 3);

        // game_over mid-step
        run_to(212); bus_if.game_over = 1'b1;
        run_to(213); bus_if.game_over = 1'b0;
        chk("go_accion_e213", 32'(bus_if.accion), 0);
        chk("go_running_e213", 32'(bus_if.running), 0);
        chk("go_mover_e213", 32'(bus_if.mover), 0);
        run_to(218); chk("go_mover_e218", 32'(bus_if.mover), 0);
        chk("go_accion_e218", 32'(bus_if.accion), 0);

        // restart from IDLE with down
        run_to(222); bus_if.btn_down = 1'b1;
        run_to(229); chk("restart_accion_e229", 32'(bus_if.accion), 2);
        chk("restart_running_e229", 32'(bus_if.running), 1);
        run_to(230); bus_if.btn_down = 1'b0;
        run_to(235);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
